// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
//   NUM_ROWS / NUM_COLS : keypad matrix geometry
//   kp_state_t          : scanner FSM states
//   lowest_low()        : index of the lowest active-low row
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        REL_DEBOUNCE
    } kp_state_t;

    // Lowest-index row that is pulled low; returns 0 when none is low.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   reset : synchronous, active-low; both stages reset to all ones
//   d     : asynchronous input
//   q     : synchronized output, two cycles behind d
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debouncing.
//   clk               : system clock
//   reset             : synchronous, active-low reset
//   rows              : keypad rows, asynchronous, active-low
//   cols              : column drive, active-low, exactly one bit low
//   new_key           : one-cycle pulse per accepted key press
//   key_pressed_value : one-hot last accepted key, bit = row*4 + col
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4000,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_ROWS-1:0]          rows,
    output logic [NUM_COLS-1:0]          cols,
    output logic                         new_key,
    output logic [NUM_ROWS*NUM_COLS-1:0] key_pressed_value
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0] rows_s;
    kp_state_t           state;
    logic [1:0]          col_idx;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DEB_W-1:0]    deb_cnt;
    logic [1:0]          row_q;
    logic [1:0]          col_q;
    logic                row_up;
    logic                any_low;
    logic [1:0]          col_next;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_rows_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    assign row_up   = rows_s[row_q];
    assign any_low  = ~&rows_s;
    assign col_next = col_idx + 2'd1;

    // Scanner FSM; every output is a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= SCAN;
            col_idx           <= 2'd0;
            cols              <= 4'b1110;
            new_key           <= 1'b0;
            key_pressed_value <= '0;
            scan_cnt          <= '0;
            deb_cnt           <= '0;
            row_q             <= 2'd0;
            col_q             <= 2'd0;
        end else begin
            new_key <= 1'b0;
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (any_low) begin
                            // Park on this column; it stays driven while debouncing.
                            row_q   <= lowest_low(rows_s);
                            col_q   <= col_idx;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_next;
                            cols    <= ~(NUM_COLS'(1) << col_next);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SCAN_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!row_up) begin
                        if (deb_cnt == DEB_LAST) begin
                            new_key           <= 1'b1;
                            key_pressed_value <= (NUM_ROWS*NUM_COLS)'(1) << {row_q, col_q};
                            state             <= HELD;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        // Bounce: rescan the same column from the start of its dwell.
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        state    <= SCAN;
                    end
                end
                HELD: begin
                    if (row_up) begin
                        deb_cnt <= '0;
                        state   <= REL_DEBOUNCE;
                    end
                end
                REL_DEBOUNCE: begin
                    if (row_up) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt  <= '0;
                            scan_cnt <= '0;
                            col_idx  <= col_next;
                            cols     <= ~(NUM_COLS'(1) << col_next);
                            state    <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        state <= HELD;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a switch-matrix keypad model
// drives rows from cols, and a cycle-level behavioural reference model
// predicts cols, new_key and key_pressed_value every cycle.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        new_key;
    logic [15:0] kpv;
    logic [15:0] keys = '0;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk               (clk),
        .reset             (reset),
        .rows              (rows),
        .cols              (cols),
        .new_key           (new_key),
        .key_pressed_value (kpv)
    );

    // Switch matrix: a closed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. phase: 0 scanning, 1 press debounce, 2 held, 3 release debounce.
    logic [3:0]  m_s1, m_s2;
    int          m_phase, m_col, m_dwell, m_run, m_row, m_pcol;
    bit          m_pulse;
    logic [15:0] m_val;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [3:0] seen;
        seen = m_s2;
        if (!reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF;
            m_phase = 0; m_col = 0; m_dwell = 0; m_run = 0;
            m_row = 0; m_pcol = 0; m_pulse = 1'b0; m_val = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_s2 = m_s1;
            m_s1 = rows;
            m_pulse = 1'b0;
            case (m_phase)
                0: begin
                    if (m_dwell == SCAN_DIV - 1) begin
                        m_dwell = 0;
                        if (seen != 4'hF) begin
                            for (int i = 3; i >= 0; i--) if (!seen[i]) m_row = i;
                            m_pcol = m_col;
                            m_run = 0;
                            m_phase = 1;
                        end else begin
                            m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_dwell++;
                    end
                end
                1: begin
                    if (!seen[m_row]) begin
                        if (m_run == DEB - 1) begin
                            m_pulse = 1'b1;
                            m_val = 16'd1 << (m_row * 4 + m_pcol);
                            m_phase = 2;
                        end else m_run++;
                    end else begin
                        m_run = 0; m_dwell = 0; m_phase = 0;
                    end
                end
                2: if (seen[m_row]) begin m_run = 0; m_phase = 3; end
                default: begin
                    if (seen[m_row]) begin
                        if (m_run == DEB - 1) begin
                            m_run = 0; m_dwell = 0; m_phase = 0;
                            m_col = (m_col + 1) % 4;
                        end else m_run++;
                    end else m_phase = 2;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cols", cols, 4'hF ^ (4'h1 << m_col));
            check("new_key", new_key, m_pulse);
            check("key_value", kpv, m_val);
        end
        if (new_key === 1'b1) pulses++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] step_exp [4];
        int k;
        bit found;
        step_exp = '{4'hD, 4'hB, 4'h7, 4'hE};

        // 1: reset for 3 edges, then free-running scan
        reset = 1'b0;
        keys  = '0;
        idle(3);
        reset = 1'b1;
        check("rst_cols", cols, 4'hE);
        check("rst_new_key", new_key, 0);
        check("rst_value", kpv, 0);
        for (int i = 0; i < 4; i++) begin
            idle(SCAN_DIV);
            check("scan_step", cols, step_exp[i]);
        end

        // 2: clean press of row 2 / col 1
        pulses = 0;
        keys = 16'h0200;
        idle(100);
        check("t2_parked", cols, 4'hD);
        keys = '0;
        idle(40);
        check("t2_pulses", pulses, 1);
        check("t2_value", kpv, 16'h0200);

        // 3: bouncing row 0 / col 3 never accepted
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            keys = (i % 4 < 3) ? 16'h0008 : 16'h0000;
            idle(1);
        end
        keys = '0;
        idle(30);
        check("t3_pulses", pulses, 0);
        check("t3_value", kpv, 16'h0200);

        // 4: release bounce on key 0/0, then clean release resumes at col 1
        pulses = 0;
        keys = 16'h0001;
        idle(60);
        check("t4_value", kpv, 16'h0001);
        repeat (4) begin
            keys = '0;
            idle(5);
            keys = 16'h0001;
            idle(3);
        end
        check("t4_parked", cols, 4'hE);
        keys = '0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle(1);
            if (cols !== 4'hE) found = 1'b1;
        end
        check("t4_resume_seen", found, 1);
        check("t4_resume_col", cols, 4'hD);
        idle(20);
        check("t4_pulses", pulses, 1);

        // 5: two rows in col 2, lowest wins; another column ignored while held
        pulses = 0;
        keys = 16'h4040;
        idle(60);
        check("t5_value", kpv, 16'h0040);
        keys = keys | 16'h0001;
        idle(30);
        check("t5_pulses", pulses, 1);
        check("t5_parked", cols, 4'hB);
        keys = '0;
        idle(40);

        // 6: reset 4 cycles into press debounce drops the press
        pulses = 0;
        keys = 16'h0020;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            idle(1);
            if (m_phase == 1 && m_run == 4) found = 1'b1;
        end
        check("t6_reached_debounce", found, 1);
        reset = 1'b0;
        keys = '0;
        idle(1);
        check("t6_rst_cols", cols, 4'hE);
        check("t6_rst_new_key", new_key, 0);
        check("t6_rst_value", kpv, 0);
        reset = 1'b1;
        idle(30);
        check("t6_pulses", pulses, 0);

        // Random presses, holds, bounces and idles against the model
        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 15));
            keys = 16'd1 << k;
            if ($urandom_range(0, 3) == 0) keys = keys | (16'd1 << $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 10)) begin
                    idle(int'($urandom_range(1, 6)));
                    keys = keys ^ (16'd1 << k);
                end
            end
            idle(int'($urandom_range(1, 80)));
            keys = '0;
            idle(int'($urandom_range(1, 50)));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
